alu_sequencer: RTL and testbench
================================

Name: alu_sequencer

Overview:
- Control FSM that sits directly upstream of the multi-stage ALU datapath.
- Latches a 10-bit instruction and sequences the register-file and bus controls over 1–3 clock cycles.
- Drives ALUcont, enA, enGin and enGout into the ALU stage, plus one-hot Rin/Rout selects for a 4-entry register file and an EXTERN bus-drive enable.
- Guarantees exactly one bus driver per cycle.

Parameters:
- IW, 10: instruction width. Fixed by the field layout; other values are unsupported.
- LOAD_OP, 4'h0: opcode for Rx <- external data bus.
- MOV_OP, 4'h1: opcode for Rx <- Ry.

Ports:
- CLK  input  1  rising-edge clock.
- RSTn  input  1  synchronous, active-low reset.
- EXEC  input  1  start request; sampled when idle.
- INSTR  input  10  instruction: [9:6] opcode, [5:4] ignored, [3:2] Rx, [1:0] Ry.
- ALUcont  output  4  ALU function select.
- enA  output  1  ALU A-register load enable.
- enGin  output  1  ALU G-register load enable.
- enGout  output  1  ALU G tristate output enable.
- Rin  output  4  one-hot register-file load enables.
- Rout  output  4  one-hot register-file bus-drive enables.
- EXTERN  output  1  external data drives the bus.
- BUSY  output  1  high in any non-IDLE state.
- DONE  output  1  one-cycle pulse in the final cycle of an instruction.

Behaviour:
- Clocking and reset:
  - Single clock CLK. Reset is synchronous, active-low.
  - RSTn=0 at a CLK edge forces state=IDLE and IR=0.
  - Reset overrides EXEC. Reset mid-instruction aborts it with no DONE.
- Outputs are Moore-style, decoded from state and IR. All outputs are 0 in IDLE and after reset.
- States are IDLE, T1, T2, T3.
  - IDLE: if EXEC=1, IR<=INSTR and next state is T1; otherwise stay in IDLE.
- LOAD (IR op == LOAD_OP), in T1:
  - EXTERN=1, Rin[Rx]=1, DONE=1.
  - Next state is IDLE.
- MOV (IR op == MOV_OP), in T1:
  - Rout[Ry]=1, Rin[Rx]=1, DONE=1.
  - Next state is IDLE.
- ALU op (any other opcode):
  - T1: Rout[Rx]=1, enA=1. Next state T2.
  - T2: Rout[Ry]=1, enGin=1, ALUcont=IR[9:6]. Next state T3.
  - T3: enGout=1, Rin[Rx]=1, DONE=1. Next state IDLE.
- ALUcont is 4'b0000 in every state except T2. The opcode passes through unmodified; its meaning is defined by the ALU.
- Latency from the EXEC-accepting edge to the DONE cycle:
  - 1 cycle for LOAD/MOV.
  - 3 cycles for ALU ops.
- Rx == Ry is legal; register selects behave the same as for distinct registers.
- EXEC while BUSY is ignored, except as described under Optional Feature. INSTR changes after acceptance have no effect.
- Invariant, every cycle: (popcount(Rout) + EXTERN + enGout) <= 1, and popcount(Rin) <= 1.

Optional Feature:
- Macro: ALU_SEQ_BACKTOBACK_EN.
- Defined:
  - In a DONE cycle (T1 of LOAD/MOV, or T3 of an ALU op), EXEC=1 latches INSTR into IR and the next state is T1, not IDLE.
  - BUSY stays high, giving zero bubble between instructions.
- Undefined:
  - EXEC is ignored in the DONE cycle.
  - A minimum of one IDLE cycle separates instructions.

Decomposition:
- Package alu_seq_pkg holds:
  - the state enum (IDLE, T1, T2, T3);
  - the LOAD_OP/MOV_OP constants;
  - the field bit positions (OP_MSB/OP_LSB, RX_MSB/RX_LSB, RY_MSB/RY_LSB).
- Sub-module dec2to4: 2-bit to one-hot decoder with enable, instantiated for Rin and Rout.

Test Plan:
- Reset: RSTn=0 for 2 cycles, EXEC=1 → all outputs 0, BUSY=0, no state advance.
- LOAD: EXEC with INSTR=10'b0000_00_10_00 → next cycle EXTERN=1, Rin=4'b0100, DONE=1, then idle.
- MOV: INSTR=10'b0001_00_01_11 → one cycle with Rout=4'b1000, Rin=4'b0010, DONE=1.
- ALU op: INSTR=10'b0101_00_00_01 → the following sequence, with no overlapping bus drivers:
  - T1: Rout=0001, enA=1.
  - T2: Rout=0010, enGin=1, ALUcont=4'b0101.
  - T3: enGout=1, Rin=0001, DONE=1.
- EXEC held high through an ALU op while INSTR changes:
  - Without the macro: the second instruction starts only after one IDLE cycle.
  - With the macro: it starts in the cycle immediately after DONE.
- Reset asserted during T2 → next cycle IDLE, all outputs 0, no DONE. A subsequent EXEC executes normally.

Source files
------------

// File: rtl/alu_seq_pkg.sv
// Shared types and constants for the ALU control sequencer.
// Instruction layout: [9:6] opcode, [5:4] unused, [3:2] Rx, [1:0] Ry.
package alu_seq_pkg;

    localparam int IW = 10;

    localparam int OP_MSB = 9;
    localparam int OP_LSB = 6;
    localparam int RX_MSB = 3;
    localparam int RX_LSB = 2;
    localparam int RY_MSB = 1;
    localparam int RY_LSB = 0;

    localparam logic [3:0] LOAD_OP = 4'h0;
    localparam logic [3:0] MOV_OP  = 4'h1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        T1   = 2'd1,
        T2   = 2'd2,
        T3   = 2'd3
    } state_t;

endpackage

// File: rtl/dec2to4.sv
// 2-bit to one-hot decoder with enable; all-zero output when disabled.
module dec2to4 (
    input  logic       en,
    input  logic [1:0] sel,
    output logic [3:0] onehot
);

    assign onehot = en ? (4'b0001 << sel) : 4'b0000;

endmodule

// File: rtl/alu_sequencer.sv
// Control FSM ahead of the multi-stage ALU: sequences register-file and bus controls per instruction.
// Optional macro ALU_SEQ_BACKTOBACK_EN lets EXEC in a DONE cycle start the next instruction with no idle bubble.
//
// state | meaning
// IDLE  | waiting for EXEC, all controls low
// T1    | LOAD/MOV transfer (final) or ALU op: Rx onto bus into A
// T2    | ALU op: Ry onto bus, result into G
// T3    | ALU op: G onto bus into Rx (final)
module alu_sequencer
    import alu_seq_pkg::*;
(
    input  logic          CLK,
    input  logic          RSTn,
    input  logic          EXEC,
    input  logic [IW-1:0] INSTR,
    output logic [3:0]    ALUcont,
    output logic          enA,
    output logic          enGin,
    output logic          enGout,
    output logic [3:0]    Rin,
    output logic [3:0]    Rout,
    output logic          EXTERN,
    output logic          BUSY,
    output logic          DONE
);

    state_t        state_q, state_d;
    logic [IW-1:0] ir_q;
    logic          load_ir;
    logic          rin_en, rout_en;
    logic [1:0]    rin_sel, rout_sel;
    logic [3:0]    op;
    logic [1:0]    rx, ry;
    logic          unused_ir_bits;

    assign op = ir_q[OP_MSB:OP_LSB];
    assign rx = ir_q[RX_MSB:RX_LSB];
    assign ry = ir_q[RY_MSB:RY_LSB];
    assign unused_ir_bits = ^ir_q[5:4];

    always_ff @(posedge CLK) begin
        if (!RSTn) begin
            state_q <= IDLE;
            ir_q    <= '0;
        end else begin
            state_q <= state_d;
            if (load_ir) ir_q <= INSTR;
        end
    end

    always_comb begin
        state_d  = state_q;
        load_ir  = 1'b0;
        rin_en   = 1'b0;
        rin_sel  = rx;
        rout_en  = 1'b0;
        rout_sel = rx;
        ALUcont  = 4'b0000;
        enA      = 1'b0;
        enGin    = 1'b0;
        enGout   = 1'b0;
        EXTERN   = 1'b0;
        DONE     = 1'b0;

        case (state_q)
            IDLE: begin
                if (EXEC) begin
                    load_ir = 1'b1;
                    state_d = T1;
                end
            end
            T1: begin
                if (op == LOAD_OP) begin
                    EXTERN  = 1'b1;
                    rin_en  = 1'b1;
                    DONE    = 1'b1;
                    state_d = IDLE;
                end else if (op == MOV_OP) begin
                    rout_en  = 1'b1;
                    rout_sel = ry;
                    rin_en   = 1'b1;
                    DONE     = 1'b1;
                    state_d  = IDLE;
                end else begin
                    rout_en = 1'b1;
                    enA     = 1'b1;
                    state_d = T2;
                end
            end
            T2: begin
                rout_en  = 1'b1;
                rout_sel = ry;
                enGin    = 1'b1;
                ALUcont  = op;
                state_d  = T3;
            end
            T3: begin
                enGout  = 1'b1;
                rin_en  = 1'b1;
                DONE    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

`ifdef ALU_SEQ_BACKTOBACK_EN
        // Chain straight into the next instruction from the final cycle.
        if (DONE && EXEC) begin
            load_ir = 1'b1;
            state_d = T1;
        end
`endif
    end

    assign BUSY = (state_q != IDLE);

    dec2to4 u_rin (
        .en     (rin_en),
        .sel    (rin_sel),
        .onehot (Rin)
    );

    dec2to4 u_rout (
        .en     (rout_en),
        .sel    (rout_sel),
        .onehot (Rout)
    );

endmodule

// File: tb/tb_alu_sequencer.sv
// Scoreboard bench for alu_sequencer: stimulus queues expected per-cycle controls, monitor checks them.
module tb_alu_sequencer;

    logic       CLK = 1'b0;
    logic       RSTn = 1'b0;
    logic       EXEC = 1'b0;
    logic [9:0] INSTR = '0;
    logic [3:0] ALUcont;
    logic       enA, enGin, enGout;
    logic [3:0] Rin, Rout;
    logic       EXTERN, BUSY, DONE;

    alu_sequencer dut (
        .CLK     (CLK),
        .RSTn    (RSTn),
        .EXEC    (EXEC),
        .INSTR   (INSTR),
        .ALUcont (ALUcont),
        .enA     (enA),
        .enGin   (enGin),
        .enGout  (enGout),
        .Rin     (Rin),
        .Rout    (Rout),
        .EXTERN  (EXTERN),
        .BUSY    (BUSY),
        .DONE    (DONE)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        int          cyc;
        logic [16:0] v;
    } rec_t;

    rec_t q[$];
    int   cyc = 0;
    int   n_vec = 0;
    int   n_fail = 0;
    logic mon_en = 1'b0;
    logic final_chk = 1'b0;
    logic final_done = 1'b0;
    logic [16:0] obs;

    assign obs = {ALUcont, enA, enGin, enGout, Rin, Rout, EXTERN, DONE};

    always @(posedge CLK) cyc <= cyc + 1;

    function automatic logic [16:0] pk(logic [3:0] alu, logic ena, logic engin, logic engout,
                                       logic [3:0] rin, logic [3:0] rout, logic ext, logic done);
        return {alu, ena, engin, engout, rin, rout, ext, done};
    endfunction

    task automatic expect_at(int c, logic [16:0] v);
        rec_t r;
        r.cyc = c;
        r.v   = v;
        q.push_back(r);
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    // Monitor: checks bus invariant every cycle, pops on BUSY cycles, requires quiet outputs when idle.
    always @(negedge CLK) begin
        rec_t r;
        if (mon_en) begin
            n_vec = n_vec + 1;
            if (($countones(Rout) + int'(EXTERN) + int'(enGout) > 1) || ($countones(Rin) > 1)) begin
                n_fail = n_fail + 1;
                $display("FAIL bus_invariant cyc=%0d Rout=%b EXTERN=%b enGout=%b Rin=%b", cyc, Rout, EXTERN, enGout, Rin);
            end
            n_vec = n_vec + 1;
            if (BUSY === 1'b1) begin
                if (q.size() == 0) begin
                    n_fail = n_fail + 1;
                    $display("FAIL unexpected_busy cyc=%0d outs=%b expected none", cyc, obs);
                end else begin
                    r = q.pop_front();
                    if (r.cyc != cyc || r.v !== obs) begin
                        n_fail = n_fail + 1;
                        $display("FAIL step_outs cyc=%0d got=%b expected cyc=%0d outs=%b", cyc, obs, r.cyc, r.v);
                    end
                end
            end else if (BUSY !== 1'b0 || obs !== 17'b0) begin
                n_fail = n_fail + 1;
                $display("FAIL idle_outs cyc=%0d BUSY=%b outs=%b expected BUSY=0 outs=0", cyc, BUSY, obs);
            end
            if (final_chk && !final_done) begin
                final_done = 1'b1;
                n_vec = n_vec + 1;
                if (q.size() != 0) begin
                    n_fail = n_fail + 1;
                    $display("FAIL leftover_expect got=%0d pending expected 0", q.size());
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog timeout at cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int c;
        int m;

        // Reset held with EXEC high: must stay idle
        RSTn  = 1'b0;
        EXEC  = 1'b1;
        INSTR = 10'b0000_00_10_00;
        step();
        mon_en = 1'b1;
        step();
        RSTn = 1'b1;
        EXEC = 1'b0;
        step();

        // LOAD R2 <- bus
        c = cyc;
        INSTR = 10'b0000_00_10_00;
        EXEC  = 1'b1;
        expect_at(c + 1, pk(4'h0, 0, 0, 0, 4'b0100, 4'b0000, 1, 1));
        step();
        EXEC = 1'b0;
        step(); step();

        // MOV R1 <- R3
        c = cyc;
        INSTR = 10'b0001_00_01_11;
        EXEC  = 1'b1;
        expect_at(c + 1, pk(4'h0, 0, 0, 0, 4'b0010, 4'b1000, 0, 1));
        step();
        EXEC = 1'b0;
        step(); step();

        // ALU op 5, Rx=0 Ry=1
        c = cyc;
        INSTR = 10'b0101_00_00_01;
        EXEC  = 1'b1;
        expect_at(c + 1, pk(4'h0, 1, 0, 0, 4'b0000, 4'b0001, 0, 0));
        expect_at(c + 2, pk(4'h5, 0, 1, 0, 4'b0000, 4'b0010, 0, 0));
        expect_at(c + 3, pk(4'h0, 0, 0, 1, 4'b0001, 4'b0000, 0, 1));
        step();
        EXEC = 1'b0;
        step(); step(); step(); step();

        // ALU op F, Rx == Ry = 2, ignored bits set
        c = cyc;
        INSTR = 10'b1111_11_10_10;
        EXEC  = 1'b1;
        expect_at(c + 1, pk(4'h0, 1, 0, 0, 4'b0000, 4'b0100, 0, 0));
        expect_at(c + 2, pk(4'hF, 0, 1, 0, 4'b0000, 4'b0100, 0, 0));
        expect_at(c + 3, pk(4'h0, 0, 0, 1, 4'b0100, 4'b0000, 0, 1));
        step();
        EXEC = 1'b0;
        step(); step(); step(); step();

        // EXEC held through an ALU op while INSTR changes to a MOV
        c = cyc;
        INSTR = 10'b0011_00_11_00;
        EXEC  = 1'b1;
        expect_at(c + 1, pk(4'h0, 1, 0, 0, 4'b0000, 4'b1000, 0, 0));
        expect_at(c + 2, pk(4'h3, 0, 1, 0, 4'b0000, 4'b0001, 0, 0));
        expect_at(c + 3, pk(4'h0, 0, 0, 1, 4'b1000, 4'b0000, 0, 1));
`ifdef ALU_SEQ_BACKTOBACK_EN
        m = c + 4;
`else
        m = c + 5;
`endif
        expect_at(m, pk(4'h0, 0, 0, 0, 4'b0001, 4'b0100, 0, 1));
        step();
        INSTR = 10'b0001_00_00_10;
        for (int i = c + 1; i < m; i++) step();
        EXEC = 1'b0;
        step(); step(); step();

        // Reset asserted during T2 aborts with no DONE, then a LOAD runs normally
        c = cyc;
        INSTR = 10'b0110_00_01_10;
        EXEC  = 1'b1;
        expect_at(c + 1, pk(4'h0, 1, 0, 0, 4'b0000, 4'b0010, 0, 0));
        expect_at(c + 2, pk(4'h6, 0, 1, 0, 4'b0000, 4'b0100, 0, 0));
        step();
        EXEC = 1'b0;
        step();
        RSTn = 1'b0;
        step();
        RSTn = 1'b1;
        step();
        c = cyc;
        INSTR = 10'b0000_11_11_01;
        EXEC  = 1'b1;
        expect_at(c + 1, pk(4'h0, 0, 0, 0, 4'b1000, 4'b0000, 1, 1));
        step();
        EXEC = 1'b0;
        step(); step();

        final_chk = 1'b1;
        step(); step();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
